max_pool_stream: RTL and testbench
==================================

MAX_POOL_STREAM -- requirements
Module: max_pool_stream

Interface
REQ-001 Parameter NUM_KERNELS, default 2, number of parallel feature-map lanes (one per convolution kernel).
REQ-002 Parameter PIX_W, default 8, pixel width in bits, signed two's complement.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  pixel beat valid.
REQ-006 in_sof  input  1  marks the first pixel (row 0, col 0) of a frame; qualified by in_valid.
REQ-007 in_pix  input  NUM_KERNELS*PIX_W  one conv-output pixel per kernel lane, lane k at bits [k*PIX_W +: PIX_W].
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 out_valid  output  1  pooled frame available.
REQ-010 out_ready  input  1  downstream FC neuron accepts pooled frame.
REQ-011 pooled_o  output  [NUM_KERNELS-1:0][3:0][PIX_W-1:0]  2x2 pooled map per lane, directly consumable as the FC neuron's pooledPixelArray.

Function
REQ-012 Input frame is a 4x4 map per lane, 16 beats in raster order (row-major, col 0..3); a beat transfers when in_valid && in_ready.
REQ-013 Pooling is 2x2 window, stride 2, signed maximum per lane; index 0=rows0-1/cols0-1, 1=rows0-1/cols2-3, 2=rows2-3/cols0-1, 3=rows2-3/cols2-3.
REQ-014 Beat counter 0..15 increments per transfer, wraps 15->0.
REQ-015 Even rows: store pairwise max of cols 0-1 and cols 2-3 in two per-lane partial registers; odd rows: max partial with incoming pair max and write result into the accumulating pooled register at the REQ-013 index.
REQ-016 States IDLE (count 0, no partial data), ACCUM (beats 1..15 pending), HOLD (out_valid=1); IDLE->ACCUM on first transfer, ACCUM->HOLD on transfer of beat 15, HOLD->IDLE on out_valid && out_ready.
REQ-017 out_valid rises the cycle after beat 15 transfers (latency 1); pooled_o is registered and stable while out_valid=1.
REQ-018 in_ready = !out_valid || out_ready; a new frame's first beat may transfer in the same cycle the held frame is accepted (zero bubble), transitioning HOLD->ACCUM.
REQ-019 in_sof asserted on a transfer forces that beat to be treated as beat 0; partial and accumulating state of an incomplete frame is discarded, with no output for it.
REQ-020 A transfer at count 0 without in_sof is accepted as beat 0 (sof optional at frame boundaries).
REQ-021 Equal values: maximum result is the common value; comparison is signed over the full PIX_W.
REQ-022 out_valid=1 with out_ready=0 holds pooled_o and blocks input indefinitely.

Reset
REQ-023 rst=1 at a clock edge sets out_valid=0, pooled_o=0, beat counter=0, partial registers=0, state IDLE.
REQ-024 in_ready is 1 during and immediately after reset (derived from out_valid=0).
REQ-025 Reset mid-frame or while HOLD discards all data; no output produced for that frame.

Configuration
REQ-026 Macro MAX_POOL_RELU_EN: when defined, each pooled value written to pooled_o is clamped to 0 if negative (ReLU after pooling); when undefined, pooled values pass unmodified, negatives included.

Structure
REQ-027 Shared package cnn_pkg holds MAP_DIM=4, POOL_DIM=2, POOL_OUT=4, the pooled-array typedef, and the state enum shared with the FC stage.
REQ-028 One sub-module max_pool_lane (one instance per kernel) holds partial registers, signed max logic and the optional clamp; the top holds the counter, FSM and handshake.

Verification
REQ-029 Frame lane0 pixels 0..15 ascending, out_ready=1 -> one cycle after beat 15, out_valid=1, lane0 pooled = {15,13,7,5} for indices 3,2,1,0.
REQ-030 Lane1 all -3 (0xFD) -> pooled all 0xFD without MAX_POOL_RELU_EN; all 0x00 with it.
REQ-031 out_ready=0 for 10 cycles after out_valid -> pooled_o stable, in_ready=0, no beats taken; out_ready=1 with next frame's beat 0 valid -> both transfers occur in the same cycle.
REQ-032 in_sof asserted at beat 7 of a frame, then 15 more beats -> exactly one output, computed only from the 16 beats starting at the sof beat.
REQ-033 rst pulsed at beat 9, then full frame -> outputs reflect only post-reset frame; out_valid=0, pooled_o=0 the cycle after reset.
REQ-034 Back-to-back 3 frames with random in_valid gaps -> 3 outputs, each matching a reference max-pool model.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN stage definitions: map geometry, pooled-array type and the
// stream state enum used by the pooling and FC stages.
package cnn_pkg;

   localparam int unsigned MAP_DIM   = 4;
   localparam int unsigned POOL_DIM  = 2;
   localparam int unsigned POOL_OUT  = 4;
   localparam int unsigned DEF_PIX_W = 8;

   typedef logic [POOL_OUT-1:0][DEF_PIX_W-1:0] pooled_arr_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } pool_state_e;

   // Raster beat (row*4+col) to pooled index: {row/2, col/2}.
   function automatic logic [1:0] pool_index(input logic [3:0] beat);
      return {beat[3], beat[1]};
   endfunction

endpackage

// File: rtl/max_pool_lane.sv
// One feature-map lane of the 2x2/stride-2 signed max pool.
// Optional ReLU clamp on pooled writes enabled by macro MAX_POOL_RELU_EN.
module max_pool_lane
   import cnn_pkg::*;
#(
   parameter int unsigned PIX_W = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             beat_en,
   input  logic [3:0]                       beat,
   input  logic [PIX_W-1:0]                 pix,
   output logic [POOL_OUT-1:0][PIX_W-1:0]   pooled
);

   logic [POOL_DIM-1:0][PIX_W-1:0] partial;
   logic [PIX_W-1:0]               sel_part;
   logic [PIX_W-1:0]               merged;
   logic [PIX_W-1:0]               clamped;
   logic                           odd_row;
   logic                           second_col;

   always_comb begin
      odd_row    = beat[2];
      second_col = beat[0];
      sel_part   = partial[beat[1]];
      merged     = ($signed(pix) > $signed(sel_part)) ? pix : sel_part;
`ifdef MAX_POOL_RELU_EN
      clamped    = merged[PIX_W-1] ? '0 : merged;
`else
      clamped    = merged;
`endif
   end

   // Column pairs fold into partial[col/2]; the second column of an odd row
   // completes the 2x2 window and lands in the pooled register.
   always_ff @(posedge clk) begin
      if (rst) begin
         partial <= '0;
         pooled  <= '0;
      end else if (beat_en) begin
         if (!odd_row && !second_col) begin
            partial[beat[1]] <= pix;
         end else if (!(odd_row && second_col)) begin
            partial[beat[1]] <= merged;
         end else begin
            pooled[pool_index(beat)] <= clamped;
         end
      end
   end

endmodule

// File: rtl/max_pool_stream.sv
// Streaming 4x4 -> 2x2 max pool over NUM_KERNELS lanes with a one-frame
// output hold. Optional post-pool ReLU via macro MAX_POOL_RELU_EN.
module max_pool_stream
   import cnn_pkg::*;
#(
   parameter int unsigned NUM_KERNELS = 2,
   parameter int unsigned PIX_W       = 8
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          in_valid,
   input  logic                                          in_sof,
   input  logic [NUM_KERNELS*PIX_W-1:0]                  in_pix,
   output logic                                          in_ready,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic [NUM_KERNELS-1:0][POOL_OUT-1:0][PIX_W-1:0] pooled_o
);

   localparam int unsigned BEATS = MAP_DIM * MAP_DIM;

   pool_state_e state;
   logic [3:0]  count;
   logic [3:0]  beat;
   logic        xfer;

   always_comb begin
      in_ready = !out_valid || out_ready;
      xfer     = in_valid && in_ready;
      beat     = in_sof ? '0 : count;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         out_valid <= 1'b0;
      end else begin
         if (xfer) begin
            count <= beat + 4'd1;
         end
         case (state)
            IDLE: begin
               if (xfer) begin
                  state <= ACCUM;
               end
            end
            ACCUM: begin
               if (xfer && beat == 4'(BEATS - 1)) begin
                  state     <= HOLD;
                  out_valid <= 1'b1;
               end
            end
            HOLD: begin
               // Acceptance of the held frame may coincide with the next frame's beat 0.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= xfer ? ACCUM : IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   for (genvar k = 0; k < NUM_KERNELS; k++) begin : g_lane
      max_pool_lane #(
         .PIX_W (PIX_W)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .beat_en (xfer),
         .beat    (beat),
         .pix     (in_pix[k*PIX_W +: PIX_W]),
         .pooled  (pooled_o[k])
      );
   end

endmodule

// File: tb/tb_max_pool_stream.sv
// Self-checking bench for max_pool_stream against a whole-frame max-pool model.
module tb_max_pool_stream;
   import cnn_pkg::*;

   localparam int NK = 2;
   localparam int PW = 8;

   typedef logic [NK-1:0][3:0][PW-1:0] pool_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_sof;
   logic [NK*PW-1:0] in_pix;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   pool_t            pooled_o;

   int total = 0;
   int bad   = 0;
   int n_out = 0;
   int n_exp = 0;

   pool_t            exp_q[$];
   logic [NK*PW-1:0] frame[16];

   always #5 clk = ~clk;

   max_pool_stream #(
      .NUM_KERNELS (NK),
      .PIX_W       (PW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_pix    (in_pix),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pooled_o  (pooled_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: each window maximum taken over the whole frame as integers.
   function automatic pool_t ref_pool();
      pool_t r;
      for (int k = 0; k < NK; k++) begin
         for (int w = 0; w < 4; w++) begin
            int r0 = (w / 2) * 2;
            int c0 = (w % 2) * 2;
            int best = -100000;
            for (int dr = 0; dr < 2; dr++) begin
               for (int dc = 0; dc < 2; dc++) begin
                  logic [NK*PW-1:0] word = frame[(r0 + dr) * 4 + c0 + dc];
                  int p = $signed(word[k*PW +: PW]);
                  if (p > best) best = p;
               end
            end
`ifdef MAX_POOL_RELU_EN
            if (best < 0) best = 0;
`endif
            r[k][w] = PW'(best);
         end
      end
      return r;
   endfunction

   task automatic gen_frame(input int mode);
      for (int b = 0; b < 16; b++) begin
         for (int k = 0; k < NK; k++) begin
            int v;
            if (mode == 1) v = int'($urandom_range(0, 4)) - 2;
            else           v = int'($urandom);
            frame[b][k*PW +: PW] = PW'(v);
         end
      end
   endtask

   task automatic send_beat(input logic [NK*PW-1:0] px, input logic sof);
      int n = 0;
      in_pix   = px;
      in_sof   = sof;
      in_valid = 1'b1;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) check("in_ready_timeout", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic send_range(input int first, input int last, input logic sof_first, input int maxgap);
      for (int b = first; b <= last; b++) begin
         int gap = int'($urandom_range(0, maxgap));
         repeat (gap) begin
            @(posedge clk); #1;
         end
         send_beat(frame[b], sof_first && (b == first));
      end
   endtask

   task automatic finish_frame(input int first, input logic sof_first, input int maxgap);
      send_range(first, 14, sof_first, maxgap);
      check("early_valid", 64'(out_valid), 64'd0);
      send_beat(frame[15], 1'b0);
      check("lat1_valid", 64'(out_valid), 64'd1);
      exp_q.push_back(ref_pool());
      n_exp++;
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         check("out_avail", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            check("pooled", pooled_o, exp_q.pop_front());
            n_out++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      pool_t held;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      in_pix    = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_pooled", pooled_o, 64'd0);
      rst = 1'b0;

      // Ascending lane 0, constant -3 lane 1.
      for (int b = 0; b < 16; b++) begin
         frame[b][0 +: PW]  = PW'(b);
         frame[b][PW +: PW] = 8'hFD;
      end
      finish_frame(0, 1'b1, 0);
      check("lane0_pool", 64'(pooled_o[0]), 64'h0F0D0705);
`ifdef MAX_POOL_RELU_EN
      check("lane1_pool", 64'(pooled_o[1]), 64'h00000000);
`else
      check("lane1_pool", 64'(pooled_o[1]), 64'hFDFDFDFD);
`endif

      // Output stall, then zero-bubble handover to the next frame.
      @(posedge clk); #1;
      gen_frame(0);
      out_ready = 1'b0;
      finish_frame(0, 1'b1, 2);
      held = exp_q[$];
      gen_frame(0);
      in_pix   = frame[0];
      in_sof   = 1'b1;
      in_valid = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         check("stall_in_ready", 64'(in_ready), 64'd0);
         check("stall_valid", 64'(out_valid), 64'd1);
         check("stall_hold", pooled_o, held);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      check("zb_valid_drop", 64'(out_valid), 64'd0);
      finish_frame(1, 1'b0, 1);

      // sof restart at beat 7 discards the partial frame.
      gen_frame(0);
      send_range(0, 6, 1'b1, 1);
      gen_frame(0);
      finish_frame(0, 1'b1, 1);

      // Reset at beat 9 discards the frame and clears outputs.
      gen_frame(0);
      send_range(0, 8, 1'b1, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_pooled", pooled_o, 64'd0);
      check("mid_rst_ready", 64'(in_ready), 64'd1);
      gen_frame(0);
      finish_frame(0, 1'b0, 1);

      // Back-to-back frames with random gaps, then near-equal small values.
      for (int f = 0; f < 6; f++) begin
         gen_frame(f < 3 ? 0 : 1);
         finish_frame(0, 1'($urandom_range(0, 1)), 3);
      end

      repeat (5) @(posedge clk);
      #1;
      check("out_count", 64'(n_out), 64'(n_exp));
      check("q_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
